// File: rtl/clock_timebase_if.sv
// clock_timebase_if: run/adjust controls and registered time outputs of the timebase.
interface clock_timebase_if;
    logic       EN;
    logic       Adj_Min;
    logic       Adj_Hour;
    logic [7:0] Second;
    logic [7:0] Minute;
    logic [7:0] Hour_BCD;
    logic [4:0] Hour;
    logic       CP_Second;
    logic       CP_Hour;
    modport master (
        output EN, Adj_Min, Adj_Hour,
        input  Second, Minute, Hour_BCD, Hour, CP_Second, CP_Hour
    );
    modport slave (
        input  EN, Adj_Min, Adj_Hour,
        output Second, Minute, Hour_BCD, Hour, CP_Second, CP_Hour
    );
endinterface

// File: rtl/clock_timebase.sv
// clock_timebase: one-second prescaler plus BCD/binary HH:MM:SS counters with set inputs.
module clock_timebase #(
    parameter int CLK_HZ = 100_000_000
) (
    input logic             CP,
    input logic             CR,
    clock_timebase_if.slave bus
);
    localparam int W = $clog2(CLK_HZ);
    logic [W-1:0] presc;
    logic adj_min_q, adj_hour_q;
    logic min_edge, hour_edge, adj, tc, tick, sec_wrap, min_wrap, min_step, hour_step;
    function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] last);
        return v == last ? 8'h00 :
               v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
    assign min_edge  = bus.Adj_Min & ~adj_min_q;
    assign hour_edge = bus.Adj_Hour & ~adj_hour_q;
    assign adj       = min_edge | hour_edge;
    assign tc        = presc == W'(CLK_HZ - 1);
    // an adjust edge on terminal count wins; the prescaler parks so the tick fires next cycle
    assign tick      = bus.EN & tc & ~adj;
    assign sec_wrap  = bus.Second == 8'h59;
    assign min_wrap  = bus.Minute == 8'h59;
    assign min_step  = tick ? sec_wrap : min_edge;
    assign hour_step = tick ? sec_wrap & min_wrap : hour_edge;
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            presc         <= '0;
            adj_min_q     <= 1'b0;
            adj_hour_q    <= 1'b0;
            bus.Second    <= 8'h00;
            bus.Minute    <= 8'h00;
            bus.Hour_BCD  <= 8'h00;
            bus.Hour      <= 5'd0;
            bus.CP_Second <= 1'b0;
            bus.CP_Hour   <= 1'b0;
        end else begin
            adj_min_q     <= bus.Adj_Min;
            adj_hour_q    <= bus.Adj_Hour;
            bus.CP_Second <= tick;
            bus.CP_Hour   <= tick & sec_wrap & min_wrap;
            if (bus.EN && !(tc && adj)) presc <= tc ? '0 : presc + W'(1);
            if (tick) bus.Second <= inc_bcd(bus.Second, 8'h59);
            if (min_step) bus.Minute <= inc_bcd(bus.Minute, 8'h59);
            if (hour_step) begin
                bus.Hour_BCD <= inc_bcd(bus.Hour_BCD, 8'h23);
                bus.Hour     <= bus.Hour == 5'd23 ? 5'd0 : bus.Hour + 5'd1;
            end
        end
    end
endmodule

// File: doc/clock_timebase.md
# clock_timebase

Timekeeping core of the digital clock. Divides the system clock into a one-second tick and keeps seconds, minutes and hours in BCD, with a binary hour copy. Emits the single-cycle `CP_Second` and `CP_Hour` strobes and the 5-bit `Hour` value consumed downstream by the hourly chime/LED stage. Also provides minute/hour set inputs for user time adjustment.

## Interface
- `CLK_HZ`, default 100_000_000: system clock cycles per second; must be ≥ 2.
- `CP`  in  1  system clock; all state changes on its rising edge.
- `CR`  in  1  asynchronous, active-high reset.
- `EN`  in  1  run enable; 0 freezes the prescaler and time counting, but adjustment still works.
- `Adj_Min`  in  1  minute-set request; each rising edge adds one minute. Synchronous to `CP` and debounced upstream.
- `Adj_Hour`  in  1  hour-set request; each rising edge adds one hour. Same constraints as `Adj_Min`.
- `Second`  out  8  BCD seconds, 00–59 ([7:4] tens, [3:0] units).
- `Minute`  out  8  BCD minutes, 00–59.
- `Hour_BCD`  out  8  BCD hours, 00–23.
- `Hour`  out  5  binary hours, 0–23; always equal to `Hour_BCD`.
- `CP_Second`  out  1  one-cycle strobe per second tick.
- `CP_Hour`  out  1  one-cycle strobe on natural hour rollover.

## Operation
**Prescaler**
- Counter of width clog2(CLK_HZ); counts 0..CLK_HZ-1 while `EN`=1 and holds while `EN`=0.
- A tick occurs in a cycle where the prescaler is at CLK_HZ-1 and `EN`=1; the prescaler wraps to 0 on that edge.

**On tick**
- Seconds +1.
- Seconds 59→00 carries into minutes +1.
- Minutes 59→00 with that carry carries into hours +1.
- Hours 23→00; full day wrap is 23:59:59 → 00:00:00.

**BCD rules**
- Units 9→0 with tens +1.
- Tens/units pairs never hold illegal codes (A–F, or above 59/23).

**Adjust**
- Edge detect: `Adj_x` high and its registered previous value low.
- Minute edge: minutes +1 mod 60. No carry into hours; seconds and prescaler untouched.
- Hour edge: hours +1 mod 24. Minutes and seconds untouched.
- Both edges in the same cycle: both applied.

**Strobes**
- `CP_Second` asserts on every tick.
- `CP_Hour` asserts only when a tick carries minutes 59→00, i.e. the displayed time becomes HH:00:00.
- Adjust edges never assert either strobe.

**Collision**
- If a tick and any adjust edge fall in the same cycle, the tick is deferred exactly one cycle.
- During the deferral the prescaler holds at CLK_HZ-1, so no second is lost; adjust is applied first.
- The deferred tick then executes normally, including carries and strobes.

## Timing
- Reset (`CR`=1, async): `Second`=`Minute`=`Hour_BCD`=8'h00, `Hour`=0, `CP_Second`=`CP_Hour`=0. Prescaler and edge-detect registers are 0.
- Reset mid-operation clears immediately, with no partial carry. The first tick after `CR` falls (`EN`=1 throughout) occurs on the CLK_HZ-th rising edge.
- All outputs are registered.
- On the edge that applies a tick, the counters take their new values and `CP_Second` goes high for exactly that one cycle. `CP_Hour` goes high in the same cycle that `Hour` shows the incremented value.
- Adjust latency: counter updates on the edge after `Adj_x` is first sampled high, i.e. one cycle. A held-high `Adj_x` counts once.
- `EN` falling on the terminal-count cycle suppresses that tick; the prescaler holds at CLK_HZ-1 and ticks on the first cycle `EN` is back at 1.

## Test plan
- Reset and free run, CLK_HZ=4, `EN`=1: release `CR` → `CP_Second` pulses at cycles 4, 8, 12 (one cycle wide each); `Second` reads 01, 02, 03.
- Rollover: preset via adjust to 23:59 and run to 23:59:59 → the next tick gives 00:00:00, with `CP_Second`=1, `CP_Hour`=1 in the same cycle and `Hour`=0. At 09:59:59 the next tick gives `Hour_BCD`=8'h10, `Hour`=10.
- Adjust: at 05:59:30, one `Adj_Min` rising edge → 05:00:30 with no hour change and `CP_Hour`=0. Holding `Adj_Hour` high for 10 cycles → hours +1 only.
- Collision, CLK_HZ=4: `Adj_Min` edge in the terminal-count cycle → minute updates at that edge, seconds update one cycle later, and the next tick follows 4 cycles after that.
- `EN` gating: drop `EN` for 7 cycles mid-count → no `CP_Second` during the gap, and the tick resumes with the remaining count preserved. Adjust while `EN`=0 still works.
- Async reset asserted mid-cycle at 12:34:56 → all outputs are 0 before the next `CP` edge, and strobes stay 0 while `CR`=1.
